// File: rtl/ssd_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ssd_scan_ctrl_pkg
// Shared constants and helpers for the seven-segment scan controller.
//   SSD_N_DIGITS         number of multiplexed digit positions
//   SSD_ALL_OFF          active-low digit-enable pattern with every digit dark
//   SSD_SCAN_DIV_DEFAULT default clk cycles per digit slot (1 kHz/digit at 100 MHz)
//   SSD_DIV_W_DEFAULT    default prescaler width matching the default divider
//   slot_blank()         leading-zero blanking decision for one digit slot
// -----------------------------------------------------------------------------
package ssd_scan_ctrl_pkg;

    localparam int         SSD_N_DIGITS         = 4;
    localparam logic [3:0] SSD_ALL_OFF          = 4'b1111;
    localparam int         SSD_SCAN_DIV_DEFAULT = 100000;
    localparam int         SSD_DIV_W_DEFAULT    = 17;

    // A slot is blanked when leading-zero suppression is on and every nibble
    // from that slot up to the leftmost digit is zero. Digit0 is always shown
    // so that an all-zero value still displays a single "0".
    function automatic logic slot_blank(
        input logic [15:0] frame,
        input logic [1:0]  idx,
        input logic        blank_lz
    );
        logic z3;
        logic z2;
        logic z1;
        logic blank;
        z3 = (frame[15:12] == 4'h0);
        z2 = (frame[11:8]  == 4'h0);
        z1 = (frame[7:4]   == 4'h0);
        case (idx)
            2'd3:    blank = z3;
            2'd2:    blank = z3 & z2;
            2'd1:    blank = z3 & z2 & z1;
            default: blank = 1'b0;
        endcase
        return blank_lz & blank;
    endfunction

endpackage

// File: rtl/ssd_scan_ctrl_prescaler.sv
// -----------------------------------------------------------------------------
// scan_prescaler
// Free-running slot prescaler shared by display scan blocks. Counts
// 0..SCAN_DIV-1 while enabled and pulses tick on the last count of each slot.
// When disabled the count is frozen so a scan resumes exactly where it stopped.
//   clk   in  1  system clock
//   rst_n in  1  synchronous active-low reset (count returns to 0)
//   en    in  1  count enable
//   tick  out 1  high for the final cycle of a slot (only while enabled)
// -----------------------------------------------------------------------------
module scan_prescaler #(
    parameter int SCAN_DIV = 100000,
    parameter int DIV_W    = 17
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] CNT_ONE  = DIV_W'(1);

    logic [DIV_W-1:0] cnt;

    assign tick = en && (cnt == CNT_LAST);

    // Slot counter: wraps at SCAN_DIV-1, holds while disabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end else begin
            cnt <= cnt;
        end
    end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// -----------------------------------------------------------------------------
// ssd_scan_ctrl
// Four-digit seven-segment scan controller feeding a BCD->segment decoder.
// Time-multiplexes a latched copy of the packed digits onto one BCD nibble,
// drives one-cold active-low digit enables and an active-low decimal point,
// and optionally blanks leading zeros. The digit vector is re-latched only at
// frame boundaries so a value never tears across one scan.
//   clk      in  1   system clock
//   rst_n    in  1   synchronous active-low reset
//   en       in  1   1 = scanning, 0 = hold position with all digits dark
//   digits   in  16  packed BCD, [3:0] = rightmost digit0
//   dp_sel   in  4   decimal point request per digit position
//   blank_lz in  1   suppress leading zeros (digit0 never blanked)
//   bcd      out 4   current digit nibble (registered)
//   ssd_ctl  out 4   one-cold active-low digit enables (registered)
//   dp_n     out 1   active-low decimal point for current digit (registered)
// -----------------------------------------------------------------------------
module ssd_scan_ctrl
    import ssd_scan_ctrl_pkg::*;
#(
    parameter int SCAN_DIV = SSD_SCAN_DIV_DEFAULT,
    parameter int DIV_W    = SSD_DIV_W_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_sel,
    input  logic        blank_lz,
    output logic [3:0]  bcd,
    output logic [3:0]  ssd_ctl,
    output logic        dp_n
);

    logic        tick;
    logic [1:0]  idx;
    logic [15:0] frame;
    logic        primed;
    logic        frame_load;
    logic        lit;
    logic [3:0]  ctl_next;
    logic        dp_next;
    logic [3:0]  bcd_next;

    scan_prescaler #(
        .SCAN_DIV (SCAN_DIV),
        .DIV_W    (DIV_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .tick  (tick)
    );

    // Reload the frame while idle, on the first enabled cycle after reset,
    // or as the last slot ends, so a new value always starts at digit0.
    assign frame_load = !en || !primed || (tick && (idx == 2'd3));

    // Slot index advances once per prescaler tick and wraps 3 -> 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx <= 2'd0;
        end else if (tick) begin
            idx <= idx + 2'd1;
        end else begin
            idx <= idx;
        end
    end

    // Tear-free frame latch and first-enable tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame  <= 16'h0000;
            primed <= 1'b0;
        end else begin
            frame  <= frame_load ? digits : frame;
            primed <= primed | en;
        end
    end

    // Next output values for the current slot; blanked or disabled slots stay dark.
    always_comb begin
        lit      = 1'b0;
        ctl_next = SSD_ALL_OFF;
        dp_next  = 1'b1;
        bcd_next = frame[{idx, 2'b00} +: 4];
        lit      = en && !slot_blank(frame, idx, blank_lz);
        if (lit) begin
            ctl_next = ~(4'b0001 << idx);
            dp_next  = ~dp_sel[idx];
        end else begin
            ctl_next = SSD_ALL_OFF;
            dp_next  = 1'b1;
        end
    end

    // Registered outputs, one clock behind the slot index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcd     <= 4'h0;
            ssd_ctl <= SSD_ALL_OFF;
            dp_n    <= 1'b1;
        end else begin
            bcd     <= bcd_next;
            ssd_ctl <= ctl_next;
            dp_n    <= dp_next;
        end
    end

endmodule
